// File: rtl/frame_sync_param.sv
// Serial frame synchroniser: hunts a SYNC_W-bit word, confirms it over BACKWARD_N frames,
// then flywheels through up to FORWARD_N-1 missed sync words. Advances only on bit_en.
module frame_sync_param #(
  parameter int                SYNC_W     = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = 8'b01111110,
  parameter int                FRAME_LEN  = 64,
  parameter int                BACKWARD_N = 2,
  parameter int                FORWARD_N  = 4,
  parameter int                MAX_ERR    = 0,
  localparam int               CW         = $clog2(FRAME_LEN),
  localparam int               MW         = $clog2(FORWARD_N + 1)
) (
  input  logic          clk_out,
  input  logic          rst_n,
  input  logic          bit_en,
  input  logic          data_in,
  output logic          data_out,
  output logic          data_valid,
  output logic          is_frame_synchronized,
  output logic [1:0]    sync_state,
  output logic          frame_start,
  output logic [CW-1:0] bit_index,
  output logic [MW-1:0] miss_cnt
);

  localparam int EW = $clog2(SYNC_W + 1);
  localparam int FW = $clog2(BACKWARD_N + 1);
  localparam logic [FW-1:0] CONF_MAX = FW'(BACKWARD_N);
  localparam logic [MW-1:0] MISS_MAX = MW'(FORWARD_N);
  localparam logic [CW-1:0] IDX_LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT     = 2'b00,
    VERIFY   = 2'b11,
    LOCKED   = 2'b10,
    FLYWHEEL = 2'b01
  } state_t;

  state_t            state_q;
  logic [SYNC_W-1:0] shreg_q;
  logic [CW-1:0]     bit_idx_q;
  logic [FW-1:0]     conf_q;
  logic [MW-1:0]     miss_q;
  logic              dout_q;
  logic              dvld_q;
  logic              fs_q;

  logic [SYNC_W-1:0] diff;
  logic [EW-1:0]     err_cnt;
  logic              match;
  logic              last;

  // Hamming distance of the pre-shift window against the sync pattern.
  assign diff = shreg_q ^ SYNC_WORD;
  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < SYNC_W; i++) err_cnt = err_cnt + EW'(diff[i]);
  end
  assign match = (err_cnt <= EW'(MAX_ERR));
  assign last  = (bit_idx_q == IDX_LAST);

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      conf_q    <= '0;
      miss_q    <= '0;
      dout_q    <= 1'b0;
      dvld_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      dvld_q <= bit_en;
      fs_q   <= 1'b0;
      if (bit_en) begin
        shreg_q <= {shreg_q[SYNC_W-2:0], data_in};
        dout_q  <= shreg_q[SYNC_W-1];
        if (state_q == HUNT) begin
          bit_idx_q <= '0;
          if (match) begin
            conf_q  <= FW'(1);
            state_q <= (BACKWARD_N == 1) ? LOCKED : VERIFY;
          end
        end else begin
          bit_idx_q <= last ? '0 : bit_idx_q + CW'(1);
          if (last) begin
            case (state_q)
              VERIFY: begin
                if (match) begin
                  conf_q <= conf_q + FW'(1);
                  if (conf_q + FW'(1) == CONF_MAX) state_q <= LOCKED;
                end else begin
                  conf_q  <= '0;
                  state_q <= HUNT;
                end
              end
              LOCKED: begin
                if (match) begin
                  fs_q <= 1'b1;
                end else if (FORWARD_N == 1) begin
                  conf_q  <= '0;
                  miss_q  <= '0;
                  state_q <= HUNT;
                end else begin
                  miss_q  <= MW'(1);
                  state_q <= FLYWHEEL;
                end
              end
              FLYWHEEL: begin
                if (match) begin
                  miss_q  <= '0;
                  fs_q    <= 1'b1;
                  state_q <= LOCKED;
                end else if (miss_q + MW'(1) == MISS_MAX) begin
                  miss_q  <= '0;
                  conf_q  <= '0;
                  state_q <= HUNT;
                end else begin
                  miss_q <= miss_q + MW'(1);
                end
              end
              default: state_q <= HUNT;
            endcase
          end
        end
      end
    end
  end

  assign data_out              = dout_q;
  assign data_valid            = dvld_q;
  assign sync_state            = state_q;
  assign is_frame_synchronized = (state_q == LOCKED) || (state_q == FLYWHEEL);
  assign frame_start           = fs_q;
  assign bit_index             = bit_idx_q;
  assign miss_cnt              = miss_q;

endmodule

// File: doc/frame_sync_param.md
Name: frame_sync_param

Overview:
- Parametrised frame synchroniser for the serial decoder path.
- Hunts for a configurable sync word in the recovered bit stream. Confirms it over BACKWARD_N consecutive frames, then holds lock through up to FORWARD_N-1 consecutive missed sync words.
- Adds three things the fixed 8-bit/64-bit version lacks: a bit-enable strobe, an error-tolerant sync match, and a status/pulse interface.
- Sits between clock recovery and the Hamming block deframer/decoder.

Parameters:
SYNC_W, 8, sync word width in bits (2..32)
SYNC_WORD, 8'b01111110, sync pattern; MSB is the first bit received
FRAME_LEN, 64, bits per frame including the sync word; must be > SYNC_W, max 4096
BACKWARD_N, 2, consecutive matches (including the first) needed to enter LOCKED; >= 1
FORWARD_N, 4, consecutive missed checkpoints that drop lock; >= 1
MAX_ERR, 0, max Hamming distance still counted as a match; < SYNC_W/2

Ports:
clk_out  in  1  bit clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
bit_en  in  1  qualifies data_in; nothing advances when 0
data_in  in  1  serial input bit
data_out  out  1  delayed data bit aligned to the status outputs
data_valid  out  1  registered; 1 for exactly the cycle after each bit_en cycle
is_frame_synchronized  out  1  state is LOCKED or FLYWHEEL
sync_state  out  2  00 HUNT, 11 VERIFY, 10 LOCKED, 01 FLYWHEEL
frame_start  out  1  one-cycle pulse on every matched checkpoint while in LOCKED or FLYWHEEL
bit_index  out  CW  position within frame, CW = clog2(FRAME_LEN)
miss_cnt  out  clog2(FORWARD_N+1)  consecutive missed checkpoints

Behaviour:
- Reset (async assert, sync release): shift register, bit_index, conf_cnt, miss_cnt all 0; state HUNT; every output 0.
- Shift register, SYNC_W bits:
  - On a bit_en cycle, buf <= {buf[SYNC_W-2:0], data_in} and data_out <= buf[SYNC_W-1] (pre-shift value).
  - Latency is SYNC_W+1 enabled bits; data_out holds between enables.
- Match: popcount(buf XOR SYNC_WORD) <= MAX_ERR, evaluated on pre-shift buf, combinational.
- FSM rule: the FSM and counters update only on bit_en cycles. Define checkpoint = bit_en AND bit_index == FRAME_LEN-1.
- HUNT:
  - bit_index held at 0.
  - Match -> VERIFY, conf_cnt <= 1, bit_index <= 0.
  - If BACKWARD_N==1, match goes straight to LOCKED.
- VERIFY, LOCKED, FLYWHEEL: bit_index increments each bit_en and wraps FRAME_LEN-1 -> 0 at the checkpoint. Checkpoint action by state:
  - VERIFY, match: conf_cnt+1; reaching BACKWARD_N -> LOCKED.
  - VERIFY, miss: -> HUNT, conf_cnt <= 0. The match check resumes on the next bit_en.
  - LOCKED, match: stay, frame_start pulse.
  - LOCKED, miss: -> FLYWHEEL, miss_cnt <= 1. If FORWARD_N==1, -> HUNT instead.
  - FLYWHEEL, match: -> LOCKED, miss_cnt <= 0, frame_start pulse.
  - FLYWHEEL, miss: miss_cnt+1; reaching FORWARD_N -> HUNT, miss_cnt <= 0.
- Matches off the checkpoint are ignored outside HUNT; there is no realignment while locked.
- frame_start asserts in the cycle after the checkpoint, together with the registered state.
- Counter widths:
  - bit_index never exceeds FRAME_LEN-1.
  - conf_cnt saturates at BACKWARD_N.
  - miss_cnt saturates at FORWARD_N.
- bit_en low on the checkpoint index: the checkpoint is deferred until the next bit_en; nothing is lost.
- rst_n asserted mid-frame: immediate return to the reset values above, regardless of bit_en.

Test Plan:
- Defaults, bit_en=1, frames of 0x7E + 56 bits of 0x00 -> sync_state 00->11->10; is_frame_synchronized rises exactly 64 bits after the first sync word completes; frame_start pulses every 64 cycles.
- Defaults, sync word 0x7E then corrupted 0x7F at the next frame -> VERIFY->HUNT, no frame_start, is_frame_synchronized stays 0.
- Locked, then 3 corrupted sync words, then a good one -> 10->01 with miss_cnt 1,2,3, then back to 10 with miss_cnt 0; is_frame_synchronized stays 1. With 4 corrupted -> HUNT, is_frame_synchronized=0.
- MAX_ERR=1, locked, sync word 0x7C (1 bit error) -> counts as a match and stays LOCKED; 0x78 (2 bit errors) -> FLYWHEEL.
- bit_en toggling 1/0 every cycle, same stream as the first scenario -> identical state sequence at half rate; data_out equals data_in delayed 9 enabled bits; data_valid alternates.
- rst_n pulsed low for 1 cycle while LOCKED at bit_index=30 -> all outputs 0 immediately; relock after 2 further frames.
